// File: rtl/mls_pkg.sv
// Shared definitions for the mls_pipe gate pipeline: function-select
// encodings and the per-channel gate evaluation.
package mls_pkg;

    localparam logic [1:0] MODE_INH    = 2'd0;
    localparam logic [1:0] MODE_INH_EN = 2'd1;
    localparam logic [1:0] MODE_AND    = 2'd2;
    localparam logic [1:0] MODE_NOR    = 2'd3;

    // Widest channel vector the evaluator handles; callers zero-extend.
    localparam int EVAL_W = 32;

    // Bitwise gate evaluation across all channels at once.
    function automatic logic [EVAL_W-1:0] mls_eval(
        input logic [EVAL_W-1:0] a,
        input logic [EVAL_W-1:0] b,
        input logic [EVAL_W-1:0] c,
        input logic [EVAL_W-1:0] d,
        input logic [1:0]        mode
    );
        logic [EVAL_W-1:0] r;
        case (mode)
            MODE_INH:    r = ~(a & c) & d;
            MODE_INH_EN: r = ~(a & c) & d & b;
            MODE_AND:    r = a & c & d;
            default:     r = ~(a | c) & d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mls_popcount.sv
// Combinational count of set bits in a W-bit vector.
module mls_popcount #(
    parameter int W = 4
) (
    input  logic [W-1:0]             in_bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int PW = $clog2(W+1);

    // Ripple sum of the individual bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + PW'(in_bits[i]);
        end
    end

endmodule

// File: rtl/mls_pipe.sv
// Two-stage valid/ready pipeline evaluating W gate channels per transaction,
// reporting the result vector, its popcount and a saturating hit counter.
module mls_pipe
    import mls_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    input  logic [W-1:0]             c,
    input  logic [W-1:0]             d,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             f,
    output logic [$clog2(W+1)-1:0]   pop,
    output logic [CNT_W-1:0]         hits,
    input  logic                     clr
);

    localparam int PW = $clog2(W+1);

    logic               vld_p1;
    logic               vld_p2;
    logic [W-1:0]       f_p1;
    logic [W-1:0]       f_p2;
    logic [PW-1:0]      pop_p2;
    logic [PW-1:0]      pop_next;
    logic [W-1:0]       f_next;
    logic               rdy_p1;
    logic               rdy_p2;
    logic               accept;
    logic               move_p2;

    // Counter steps up by one but sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Ready ripples backwards combinationally so a full pipe still streams
    // at one transaction per cycle when the sink is ready.
    assign rdy_p2   = ~vld_p2 | out_ready;
    assign rdy_p1   = ~vld_p1 | rdy_p2;
    assign in_ready = rdy_p1;
    assign accept   = in_valid & rdy_p1;
    assign move_p2  = vld_p1 & rdy_p2;

    assign f_next = W'(mls_eval(32'(a), 32'(b), 32'(c), 32'(d), mode));

    mls_popcount #(.W(W)) u_popcount (
        .in_bits (f_p1),
        .count   (pop_next)
    );

    // Stage 1: capture the evaluated channel vector on input accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            f_p1   <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            f_p1   <= f_next;
        end else if (move_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 2: output register holding result and its popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            f_p2   <= '0;
            pop_p2 <= '0;
        end else if (move_p2) begin
            vld_p2 <= 1'b1;
            f_p2   <= f_p1;
            pop_p2 <= pop_next;
        end else if (out_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    // Hit counter: counts consumed non-zero results; clr wins over a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits <= '0;
        end else if (clr) begin
            hits <= '0;
        end else if (vld_p2 && out_ready && (f_p2 != '0)) begin
            hits <= sat_inc(hits);
        end
    end

    assign out_valid = vld_p2;
    assign f         = f_p2;
    assign pop       = pop_p2;

endmodule

// File: tb/tb_mls_pipe.sv
// Randomised and directed bench for mls_pipe with a queue-based reference.
module tb_mls_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, clr;
    logic [3:0] a, b, c, d;
    logic [1:0] mode;

    logic       in_ready, out_valid;
    logic [3:0] f;
    logic [2:0] pop;
    logic [7:0] hits;

    logic       in_ready2, out_valid2;
    logic [3:0] f2;
    logic [2:0] pop2;
    logic [1:0] hits2;

    mls_pipe #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .pop(pop), .hits(hits), .clr(clr)
    );

    mls_pipe #(.W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .f(f2), .pop(pop2), .hits(hits2), .clr(clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [3:0] cmp_e[$];
    logic [3:0] cmp_f[$];
    logic [2:0] cmp_p[$];
    int extra   = 0;
    int hits_m8 = 0;
    int hits_m2 = 0;

    function automatic logic [3:0] ref_f(input logic [3:0] ai, input logic [3:0] bi,
                                         input logic [3:0] ci, input logic [3:0] di,
                                         input logic [1:0] m);
        logic [3:0] r;
        logic x, y, z, w;
        for (int i = 0; i < 4; i++) begin
            x = ai[i]; y = bi[i]; z = ci[i]; w = di[i];
            case (m)
                2'd0:    r[i] = !(x && z) && w;
                2'd1:    r[i] = !(x && z) && w && y;
                2'd2:    r[i] = x && z && w;
                default: r[i] = !(x || z) && w;
            endcase
        end
        return r;
    endfunction

    // The pipe holds at most two entries; input blocks only when both are
    // occupied and the sink refuses.
    function automatic logic exp_rdy();
        return !(exp_q.size() == 2 && !out_ready);
    endfunction

    task automatic randomize_inputs();
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
        mode = 2'($urandom);
    endtask

    task automatic clear_cmp();
        cmp_e.delete(); cmp_f.delete(); cmp_p.delete(); extra = 0;
    endtask

    // One clock: update the reference from the pre-edge handshakes, then
    // advance to just after the edge.
    task automatic tick();
        logic acc, hs;
        logic [3:0] e;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_e.push_back(e); cmp_f.push_back(f); cmp_p.push_back(pop);
                if (e != 4'd0) begin
                    hits_m8 = (hits_m8 < 255) ? hits_m8 + 1 : 255;
                    hits_m2 = (hits_m2 < 3) ? hits_m2 + 1 : 3;
                end
            end else begin
                extra++;
            end
        end
        if (clr) begin hits_m8 = 0; hits_m2 = 0; end
        if (acc) exp_q.push_back(ref_f(a, b, c, d, mode));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); hits_m8 = 0; hits_m2 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0; mode = '0;
        @(posedge clk); #1;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (f !== 4'd0) begin errors++; $display("FAIL reset_f got %h exp 0", f); end
        checks++; if (pop !== 3'd0) begin errors++; $display("FAIL reset_pop got %0d exp 0", pop); end
        checks++; if (hits !== 8'd0) begin errors++; $display("FAIL reset_hits got %0d exp 0", hits); end
        checks++; if (hits2 !== 2'd0) begin errors++; $display("FAIL reset_hits2 got %0d exp 0", hits2); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [3:0] ta[4] = '{4'b1010, 4'b1010, 4'hF, 4'h0};
        logic [3:0] tb[4] = '{4'b0000, 4'b0101, 4'hF, 4'h0};
        logic [3:0] tc[4] = '{4'b1100, 4'b1100, 4'hF, 4'h0};
        logic [3:0] td[4] = '{4'b1111, 4'b1111, 4'hF, 4'b1001};
        logic [1:0] tm[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [3:0] tf[4] = '{4'b0111, 4'b0101, 4'hF, 4'b1001};
        logic [2:0] tp[4] = '{3'd3, 3'd2, 3'd4, 3'd2};
        clear_cmp();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = ta[k]; b = tb[k]; c = tc[k]; d = td[k]; mode = tm[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            randomize_inputs();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_early_valid got %b exp 0", k, out_valid); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got %b exp 1", k, out_valid); end
            checks++; if (f !== tf[k]) begin errors++; $display("FAIL mode%0d_f got %b exp %b", k, f, tf[k]); end
            checks++; if (pop !== tp[k]) begin errors++; $display("FAIL mode%0d_pop got %0d exp %0d", k, pop, tp[k]); end
            tick();
            checks++; if (hits !== 8'(k + 1)) begin errors++; $display("FAIL mode%0d_hits got %0d exp %0d", k, hits, k + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        logic pv = 1'b0, por = 1'b1, saw_block = 1'b0, acc_now;
        logic [3:0] pf = '0;
        clear_cmp();
        randomize_inputs();
        for (int k = 0; k < 40 && (sent < 6 || exp_q.size() > 0); k++) begin
            out_ready = !(k >= 3 && k <= 5);
            in_valid  = (sent < 6);
            #1;
            checks++; if (in_ready !== exp_rdy()) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b exp %b", k, in_ready, exp_rdy()); end
            if (!por && !out_ready) begin
                checks++; if (out_valid !== pv || f !== pf) begin errors++; $display("FAIL b2b_stall cyc %0d got v=%b f=%h exp v=%b f=%h", k, out_valid, f, pv, pf); end
            end
            if (!in_ready) saw_block = 1'b1;
            acc_now = in_valid && in_ready;
            pv = out_valid; pf = f; por = out_ready;
            tick();
            if (acc_now) begin sent++; randomize_inputs(); end
        end
        in_valid = 1'b0;
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_block got %b exp 1", saw_block); end
        checks++; if (cmp_e.size() != 6 || extra != 0) begin errors++; $display("FAIL b2b_count got %0d extra %0d exp 6 extra 0", cmp_e.size(), extra); end
        foreach (cmp_e[i]) begin
            checks++; if (cmp_f[i] !== cmp_e[i]) begin errors++; $display("FAIL b2b_f[%0d] got %h exp %h", i, cmp_f[i], cmp_e[i]); end
            checks++; if (cmp_p[i] !== 3'($countones(cmp_e[i]))) begin errors++; $display("FAIL b2b_pop[%0d] got %0d exp %0d", i, cmp_p[i], $countones(cmp_e[i])); end
        end
    endtask

    task automatic test_random();
        clear_cmp();
        for (int k = 0; k < 80; k++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 15) == 0);
            #1;
            checks++; if (in_ready !== exp_rdy()) begin errors++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", k, in_ready, exp_rdy()); end
            tick();
            checks++; if (hits !== 8'(hits_m8) || hits2 !== 2'(hits_m2)) begin errors++; $display("FAIL rand_hits cyc %0d got %0d/%0d exp %0d/%0d", k, hits, hits2, hits_m8, hits_m2); end
        end
        drain();
        checks++; if (exp_q.size() != 0 || out_valid !== 1'b0 || extra != 0) begin errors++; $display("FAIL rand_drain got left %0d valid %b extra %0d exp 0 0 0", exp_q.size(), out_valid, extra); end
        foreach (cmp_e[i]) begin
            checks++; if (cmp_f[i] !== cmp_e[i] || cmp_p[i] !== 3'($countones(cmp_e[i]))) begin errors++; $display("FAIL rand_data[%0d] got f=%h pop=%0d exp f=%h", i, cmp_f[i], cmp_p[i], cmp_e[i]); end
        end
    endtask

    task automatic test_hits();
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        clr = 1'b0;
        clear_cmp();
        a = 4'h0; b = 4'hF; c = 4'hF; d = 4'hF; mode = 2'd2;
        in_valid = 1'b1;
        tick();
        drain();
        checks++; if (hits !== 8'd0) begin errors++; $display("FAIL hits_zero got %0d exp 0", hits); end
        checks++; if (cmp_f.size() != 1 || cmp_f[0] !== 4'd0) begin errors++; $display("FAIL hits_zero_f got n=%0d exp one zero result", cmp_f.size()); end
        a = 4'hF;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        drain();
        checks++; if (hits !== 8'd5) begin errors++; $display("FAIL hits_count got %0d exp 5", hits); end
        checks++; if (hits2 !== 2'd3) begin errors++; $display("FAIL hits_sat got %0d exp 3", hits2); end
    endtask

    task automatic test_clr();
        a = 4'h0; c = 4'h0; d = 4'h6; mode = 2'd3;
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || f !== 4'h6) begin errors++; $display("FAIL clr_setup got v=%b f=%h exp v=1 f=6", out_valid, f); end
        out_ready = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (hits !== 8'd0 || hits2 !== 2'd0) begin errors++; $display("FAIL clr_priority got %0d/%0d exp 0/0", hits, hits2); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_consumed got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] e;
        a = 4'h0; c = 4'h0; d = 4'hF; mode = 2'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        randomize_inputs(); d = 4'hF; a = 4'h0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got in_ready %b exp 0", in_ready); end
        do_reset();
        checks++; if (out_valid !== 1'b0 || f !== 4'd0 || pop !== 3'd0) begin errors++; $display("FAIL rstmid_out got v=%b f=%h pop=%0d exp 0 0 0", out_valid, f, pop); end
        checks++; if (hits !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctl got hits=%0d rdy=%b exp 0 1", hits, in_ready); end
        randomize_inputs();
        e = ref_f(a, b, c, d, mode);
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || f !== e) begin errors++; $display("FAIL rstmid_first got v=%b f=%h exp v=1 f=%h", out_valid, f, e); end
        drain();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_random();
        test_hits();
        test_clr();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
